background_model_ctrl: RTL and testbench
========================================

Name: background_model_ctrl

Overview:
- Frame-level sequencer for the background-model pipeline. Drives its ce (bypass vs model), bg_th/fd_th/alpha, and an input stall gate.
- Switches mode and applies parameters only at frame boundaries, after flushing the fixed-latency pipeline. No frame is ever emitted partly in bypass and partly in model mode, or with mixed parameters.
- Runs a warm-up phase in bypass so the background buffer is seeded with live frames before the model is enabled.
- Sits beside the model on the same input AXI-Stream. It observes the handshake and owns the gating.

Parameters:
- LATENCY, 7, model pipeline depth in cycles; length of every drain.
- WARMUP_FRAMES, 4, complete frames passed in bypass before RUN; 0 means go straight to RUN.
- FCNT_WIDTH, 16, width of frame_count.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- enable  in  1  level; 1 requests model operation, 0 requests bypass.
- cfg_bg_th  in  8  requested background threshold.
- cfg_fd_th  in  8  requested frame-difference threshold.
- cfg_alpha  in  8  requested alpha.
- cfg_update  in  1  one-cycle pulse; latches cfg_* into shadow registers and sets cfg_pending.
- in_tvalid  in  1  ungated upstream tvalid.
- in_tready  in  1  ungated model input tready.
- in_tuser  in  1  start of frame.
- in_tlast  in  1  end of line/frame marker as used on the stream; the end of frame is the accepted tlast beat.
- stall  out  1  1 = integration gates in_tvalid and in_tready low.
- ce  out  1  model enable.
- bg_th  out  8  applied threshold.
- fd_th  out  8  applied threshold.
- alpha  out  8  applied alpha.
- state  out  2  IDLE=0, WARMUP=1, RUN=2, DRAIN=3.
- cfg_pending  out  1  shadow not yet applied.
- frame_count  out  FCNT_WIDTH  accepted frames, all states, wraps.

Behaviour:
- beat = in_tvalid & in_tready & ~stall; signals are sampled only on a beat.
- in_frame: set on a beat with tuser, cleared on a beat with tlast. tlast wins if both occur on the same beat.
- boundary = (beat & tlast) | (~in_frame & no beat this cycle).
- Reset: state=IDLE, ce=0, stall=0, in_frame=0, cfg_pending=0, frame_count=0, warm counter=0, bg_th=fd_th=alpha=0, shadow=0.
- stall = (state==DRAIN), combinational from the registered state. ce is registered and equals 1 only in RUN. It is unchanged during DRAIN, and switches to the post-drain value in the same cycle state leaves DRAIN.
- IDLE: ce=0, traffic passes in bypass.
  - Pending cfg is applied at a boundary (outputs update the next cycle).
  - enable=1 at a boundary: go to WARMUP and clear the warm counter. If WARMUP_FRAMES=0, go to DRAIN with target RUN instead.
- WARMUP: ce=0.
  - Warm counter increments on beat&tlast.
  - enable=0 at a boundary: go to IDLE (no drain needed; both are bypass).
  - Counter reaching WARMUP_FRAMES on beat&tlast: go to DRAIN with target RUN.
  - Pending cfg is applied at boundaries, as in IDLE.
- RUN: ce=1.
  - At a boundary, (enable=0) or cfg_pending: go to DRAIN. Target is IDLE if enable=0, else RUN.
- DRAIN: stall=1 for exactly LATENCY cycles (down-counter).
  - On exit, any pending cfg is applied, cfg_pending is cleared, and state becomes the target.
  - Disable and cfg_pending together use a single drain; params are applied and the target is IDLE.
  - enable changes during DRAIN are ignored until the next state evaluates them.
- cfg_update while already pending: shadow is overwritten, and the latest value wins.
- cfg_update in the same cycle as apply: the new value stays pending (applied values are the old shadow).
- frame_count increments on every beat&tlast, wraps at 2^FCNT_WIDTH.
- areset mid-frame or mid-drain: immediate return to reset values at the next edge. The upstream is responsible for resynchronising on tuser.

Test Plan:
- Reset, then enable=1 idle between frames, WARMUP_FRAMES=4: 4 frames in bypass (ce=0, state=1). After the 4th tlast beat, stall=1 for exactly 7 cycles, then ce=1, state=2.
- In RUN, cfg_update with bg_th=0x20 mid-frame: bg_th holds its old value until the frame's tlast beat. Then a 7-cycle stall, and bg_th=0x20 on DRAIN exit; cfg_pending drops.
- Two cfg_update pulses (alpha=0x10 then 0x40) within one frame in RUN: only one drain occurs, and alpha becomes 0x40.
- In RUN, enable=0 and cfg_update in the same frame: one 7-cycle drain, then state=0, ce=0, new params applied.
- In WARMUP after 2 frames, enable=0: at the next tlast beat, state=0 with no stall. Re-enable: the warm counter restarts from 0.
- areset asserted during DRAIN, cycle 3: next cycle stall=0, state=0, ce=0, frame_count=0, all params 0.

Source files
------------

// File: rtl/background_model_ctrl.sv
// background_model_ctrl
//
// Frame-level sequencer for the background-model pipeline. It watches the
// input AXI-Stream handshake and decides when the model runs (ce) and when
// new thresholds/alpha take effect. Mode and parameter changes only happen
// at frame boundaries, after the fixed-latency model pipeline has drained,
// so no output frame mixes bypass and model processing or mixes parameters.
// A warm-up phase passes a number of frames in bypass first, so the
// background buffer is seeded with live data before the model is enabled.
//
// Ports:
//   aclk         clock
//   areset       synchronous active-high reset
//   enable       level: 1 requests model operation, 0 requests bypass
//   cfg_bg_th    requested background threshold
//   cfg_fd_th    requested frame-difference threshold
//   cfg_alpha    requested alpha
//   cfg_update   one-cycle pulse: capture cfg_* into the shadow registers
//   in_tvalid    ungated upstream tvalid
//   in_tready    ungated model input tready
//   in_tuser     start-of-frame marker
//   in_tlast     end marker; an accepted tlast beat ends the frame
//   stall        1 = integration gates in_tvalid and in_tready low
//   ce           model enable (0 = bypass)
//   bg_th        applied background threshold
//   fd_th        applied frame-difference threshold
//   alpha        applied alpha
//   state        IDLE=0, WARMUP=1, RUN=2, DRAIN=3
//   cfg_pending  shadow parameters not yet applied
//   frame_count  accepted frames in every state, wraps

module background_model_ctrl #(
    parameter int unsigned LATENCY       = 7,
    parameter int unsigned WARMUP_FRAMES = 4,
    parameter int unsigned FCNT_WIDTH    = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [7:0]            cfg_bg_th,
    input  logic [7:0]            cfg_fd_th,
    input  logic [7:0]            cfg_alpha,
    input  logic                  cfg_update,
    input  logic                  in_tvalid,
    input  logic                  in_tready,
    input  logic                  in_tuser,
    input  logic                  in_tlast,
    output logic                  stall,
    output logic                  ce,
    output logic [7:0]            bg_th,
    output logic [7:0]            fd_th,
    output logic [7:0]            alpha,
    output logic [1:0]            state,
    output logic                  cfg_pending,
    output logic [FCNT_WIDTH-1:0] frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Drain counter loads LATENCY-1 and exits on zero: LATENCY stall cycles.
    localparam int unsigned DCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    // Warm counter holds completed warm-up frames; the frame that brings it
    // to WARMUP_FRAMES triggers the drain, so compare against the last index.
    localparam int unsigned WCNT_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES + 1) : 1;
    localparam logic [WCNT_W-1:0] WARM_LAST =
        WCNT_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

    state_t              cur_state;
    logic                drain_to_run;   // drain target: 1 = RUN, 0 = IDLE
    logic [DCNT_W-1:0]   drain_cnt;
    logic [WCNT_W-1:0]   warm_cnt;
    logic                in_frame;
    logic [7:0]          sh_bg_th;
    logic [7:0]          sh_fd_th;
    logic [7:0]          sh_alpha;

    logic beat;
    logic eof;
    logic boundary;
    logic drain_done;
    logic apply_cfg;

    assign state = cur_state;
    assign stall = (cur_state == ST_DRAIN);

    // Handshake as seen by the model, i.e. after our own gating.
    assign beat     = in_tvalid & in_tready & ~stall;
    assign eof      = beat & in_tlast;
    // Either the frame just ended, or we are idle between frames.
    assign boundary = eof | (~in_frame & ~beat);

    assign drain_done = (cur_state == ST_DRAIN) && (drain_cnt == '0);

    // Bypass states may change parameters at any boundary (no model output
    // to corrupt); RUN only changes them through a drain.
    always_comb begin
        apply_cfg = 1'b0;
        if (cfg_pending) begin
            if ((cur_state == ST_IDLE || cur_state == ST_WARMUP) && boundary)
                apply_cfg = 1'b1;
            else if (drain_done)
                apply_cfg = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cur_state    <= ST_IDLE;
            drain_to_run <= 1'b0;
            drain_cnt    <= '0;
            warm_cnt     <= '0;
            in_frame     <= 1'b0;
            ce           <= 1'b0;
            bg_th        <= '0;
            fd_th        <= '0;
            alpha        <= '0;
            sh_bg_th     <= '0;
            sh_fd_th     <= '0;
            sh_alpha     <= '0;
            cfg_pending  <= 1'b0;
            frame_count  <= '0;
        end else begin
            if (eof)
                frame_count <= frame_count + 1'b1;

            // tlast takes priority over tuser on the same beat.
            if (beat) begin
                if (in_tlast)
                    in_frame <= 1'b0;
                else if (in_tuser)
                    in_frame <= 1'b1;
            end

            // Apply first, then capture: an update on the apply cycle stays
            // pending, and the applied values are the previous shadow.
            if (apply_cfg) begin
                bg_th       <= sh_bg_th;
                fd_th       <= sh_fd_th;
                alpha       <= sh_alpha;
                cfg_pending <= 1'b0;
            end
            if (cfg_update) begin
                sh_bg_th    <= cfg_bg_th;
                sh_fd_th    <= cfg_fd_th;
                sh_alpha    <= cfg_alpha;
                cfg_pending <= 1'b1;
            end

            case (cur_state)
                ST_IDLE: begin
                    if (boundary && enable) begin
                        if (WARMUP_FRAMES == 0) begin
                            cur_state    <= ST_DRAIN;
                            drain_to_run <= 1'b1;
                            drain_cnt    <= DRAIN_LOAD;
                        end else begin
                            cur_state <= ST_WARMUP;
                            warm_cnt  <= '0;
                        end
                    end
                end

                ST_WARMUP: begin
                    if (eof)
                        warm_cnt <= warm_cnt + 1'b1;
                    // Disable wins over finishing warm-up on the same boundary.
                    if (boundary && !enable) begin
                        cur_state <= ST_IDLE;
                    end else if (eof && warm_cnt == WARM_LAST) begin
                        cur_state    <= ST_DRAIN;
                        drain_to_run <= 1'b1;
                        drain_cnt    <= DRAIN_LOAD;
                    end
                end

                ST_RUN: begin
                    // Disable and pending cfg share one drain; the pending
                    // parameters are applied on its exit either way.
                    if (boundary && (!enable || cfg_pending)) begin
                        cur_state    <= ST_DRAIN;
                        drain_to_run <= enable;
                        drain_cnt    <= DRAIN_LOAD;
                    end
                end

                ST_DRAIN: begin
                    // ce holds its value during the drain and flips on exit.
                    if (drain_cnt == '0) begin
                        cur_state <= drain_to_run ? ST_RUN : ST_IDLE;
                        ce        <= drain_to_run;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end

                default: cur_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_background_model_ctrl.sv
// Testbench for background_model_ctrl: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.

module tb_background_model_ctrl;

    localparam int LAT = 7;
    localparam int WF  = 4;
    localparam int FW  = 16;

    localparam int S_IDLE   = 0;
    localparam int S_WARMUP = 1;
    localparam int S_RUN    = 2;
    localparam int S_DRAIN  = 3;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b0;
    logic [7:0]    cfg_bg_th = '0;
    logic [7:0]    cfg_fd_th = '0;
    logic [7:0]    cfg_alpha = '0;
    logic          cfg_update = 1'b0;
    logic          in_tvalid = 1'b0;
    logic          in_tready = 1'b0;
    logic          in_tuser = 1'b0;
    logic          in_tlast = 1'b0;
    logic          stall;
    logic          ce;
    logic [7:0]    bg_th;
    logic [7:0]    fd_th;
    logic [7:0]    alpha;
    logic [1:0]    state;
    logic          cfg_pending;
    logic [FW-1:0] frame_count;

    always #5 aclk = ~aclk;

    background_model_ctrl #(
        .LATENCY       (LAT),
        .WARMUP_FRAMES (WF),
        .FCNT_WIDTH    (FW)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .cfg_bg_th   (cfg_bg_th),
        .cfg_fd_th   (cfg_fd_th),
        .cfg_alpha   (cfg_alpha),
        .cfg_update  (cfg_update),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .in_tuser    (in_tuser),
        .in_tlast    (in_tlast),
        .stall       (stall),
        .ce          (ce),
        .bg_th       (bg_th),
        .fd_th       (fd_th),
        .alpha       (alpha),
        .state       (state),
        .cfg_pending (cfg_pending),
        .frame_count (frame_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic bound(input string tag, input int k, input int lim);
        if (k >= lim)
            check(tag, 32'd0, 32'd1);
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_state;
    int          m_target;
    int          m_drain_left;
    int          m_warm;
    bit          m_ce;
    bit          m_pend;
    bit          m_inframe;
    bit          m_beat;
    logic [7:0]  m_sh [3];
    logic [7:0]  m_ap [3];
    int unsigned m_fcnt;

    function automatic void model_reset();
        m_state = S_IDLE; m_target = S_IDLE; m_drain_left = 0; m_warm = 0;
        m_ce = 0; m_pend = 0; m_inframe = 0; m_beat = 0; m_fcnt = 0;
        for (int i = 0; i < 3; i++) begin m_sh[i] = 8'h00; m_ap[i] = 8'h00; end
    endfunction

    function automatic void start_drain(input int target);
        m_state      = S_DRAIN;
        m_target     = target;
        m_drain_left = LAT;
    endfunction

    function automatic void model_step();
        bit beat, eof, bnd, apply;
        if (areset) begin
            model_reset();
            return;
        end
        beat  = in_tvalid && in_tready && (m_state != S_DRAIN);
        eof   = beat && in_tlast;
        bnd   = eof || (!m_inframe && !beat);
        apply = 0;
        case (m_state)
            S_IDLE: begin
                if (bnd && m_pend) apply = 1;
                if (bnd && enable) begin
                    if (WF == 0) start_drain(S_RUN);
                    else begin m_state = S_WARMUP; m_warm = 0; end
                end
            end
            S_WARMUP: begin
                if (bnd && m_pend) apply = 1;
                if (eof) m_warm++;
                if (bnd && !enable) m_state = S_IDLE;
                else if (eof && m_warm == WF) start_drain(S_RUN);
            end
            S_RUN: begin
                if (bnd && (!enable || m_pend))
                    start_drain(enable ? S_RUN : S_IDLE);
            end
            default: begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    if (m_pend) apply = 1;
                    m_state = m_target;
                    m_ce    = (m_target == S_RUN);
                end
            end
        endcase
        if (apply) begin
            for (int i = 0; i < 3; i++) m_ap[i] = m_sh[i];
            m_pend = 0;
        end
        if (cfg_update) begin
            m_sh[0] = cfg_bg_th; m_sh[1] = cfg_fd_th; m_sh[2] = cfg_alpha;
            m_pend  = 1;
        end
        if (beat) begin
            if (in_tlast) m_inframe = 0;
            else if (in_tuser) m_inframe = 1;
        end
        if (eof) m_fcnt = (m_fcnt + 1) % (32'd1 << FW);
        m_beat = beat;
    endfunction

    task automatic compare_all();
        check("state",       state,       m_state);
        check("ce",          ce,          m_ce);
        check("stall",       stall,       m_state == S_DRAIN);
        check("bg_th",       bg_th,       m_ap[0]);
        check("fd_th",       fd_th,       m_ap[1]);
        check("alpha",       alpha,       m_ap[2]);
        check("cfg_pending", cfg_pending, m_pend);
        check("frame_count", frame_count, m_fcnt);
    endtask

    // ---------------- stream generator ----------------
    int gen_pos = 0;
    int gen_len = 4;
    int gen_gap = 2;
    int len_min = 1;
    int len_max = 6;
    bit glitch_en = 0;

    task automatic set_inputs();
        if (gen_gap > 0) begin
            in_tvalid = 0; in_tuser = 0; in_tlast = 0;
        end else begin
            in_tvalid = ($urandom_range(0, 9) < 8);
            in_tuser  = (gen_pos == 0);
            in_tlast  = (gen_pos >= gen_len - 1);
        end
        in_tready = ($urandom_range(0, 9) < 9);
        if (glitch_en && $urandom_range(0, 49) == 0) begin
            in_tvalid = 1;
            in_tuser  = 1'($urandom_range(0, 1));
            in_tlast  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic advance_gen();
        if (gen_gap > 0) begin
            gen_gap--;
        end else if (m_beat) begin
            if (in_tlast) begin
                gen_pos = 0;
                gen_len = $urandom_range(len_min, len_max);
                gen_gap = $urandom_range(0, 3);
            end else begin
                gen_pos++;
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        model_step();
        @(negedge aclk);
        compare_all();
    endtask

    task automatic cyc();
        set_inputs();
        step();
        advance_gen();
    endtask

    function automatic bit mid_frame_in_run();
        return m_state == S_RUN && gen_gap == 0 && gen_pos >= 1 && gen_pos + 3 < gen_len;
    endfunction

    int k;
    int stalls;
    int drains;
    bit prev_stall;
    int unsigned f0;

    initial begin
        model_reset();

        // Reset, then enable between frames: warm-up then drain into RUN.
        areset = 1; cyc(); cyc();
        areset = 0;
        gen_gap = 3; gen_pos = 0; gen_len = 3;
        cyc();
        check("rst_state", state, 0);
        check("rst_fcnt", frame_count, 0);
        enable = 1;
        stalls = 0; k = 0;
        while (!(m_state == S_RUN) && k < 2000) begin
            cyc();
            if (stall) begin
                if (stalls == 0) check("warmup_frames", frame_count, WF);
                stalls++;
            end
            k++;
        end
        bound("warmup_timeout", k, 2000);
        check("warmup_drain_len", stalls, LAT);
        check("run_ce", ce, 1);
        check("run_state", state, 2);

        // Mid-frame cfg in RUN: held until the frame ends, applied after drain.
        len_min = 5; len_max = 9;
        k = 0;
        while (!mid_frame_in_run() && k < 500) begin cyc(); k++; end
        bound("cfg_wait_timeout", k, 500);
        cfg_bg_th = 8'h20; cfg_fd_th = 8'h21; cfg_alpha = 8'h22; cfg_update = 1;
        cyc();
        cfg_update = 0;
        check("cfg_pending_set", cfg_pending, 1);
        check("bg_hold", bg_th, 8'h00);
        stalls = 0; k = 0;
        while (!(stalls > 0 && !stall) && k < 500) begin
            cyc();
            if (stall) begin
                if (stalls == 0) check("bg_hold_at_drain", bg_th, 8'h00);
                stalls++;
            end
            k++;
        end
        bound("cfg_drain_timeout", k, 500);
        check("cfg_drain_len", stalls, LAT);
        check("bg_applied", bg_th, 8'h20);
        check("cfg_pending_clr", cfg_pending, 0);
        check("cfg_back_to_run", state, 2);

        // Two updates within one frame: one drain, latest value wins.
        k = 0;
        while (!mid_frame_in_run() && k < 500) begin cyc(); k++; end
        bound("dbl_wait_timeout", k, 500);
        cfg_alpha = 8'h10; cfg_update = 1; cyc();
        cfg_alpha = 8'h40; cfg_update = 1; cyc();
        cfg_update = 0;
        drains = 0; prev_stall = 0;
        for (int i = 0; i < 120; i++) begin
            cyc();
            if (stall && !prev_stall) drains++;
            prev_stall = stall;
        end
        check("dbl_one_drain", drains, 1);
        check("dbl_alpha", alpha, 8'h40);
        check("dbl_fd_kept", fd_th, 8'h21);

        // Disable plus cfg in the same frame: single drain into IDLE.
        k = 0;
        while (!mid_frame_in_run() && k < 500) begin cyc(); k++; end
        bound("dis_wait_timeout", k, 500);
        enable = 0;
        cfg_bg_th = 8'h55; cfg_fd_th = 8'h66; cfg_alpha = 8'h77; cfg_update = 1;
        cyc();
        cfg_update = 0;
        stalls = 0; k = 0;
        while (!(m_state == S_IDLE) && k < 500) begin
            cyc();
            if (stall) stalls++;
            k++;
        end
        bound("dis_timeout", k, 500);
        check("dis_drain_len", stalls, LAT);
        check("dis_state", state, 0);
        check("dis_ce", ce, 0);
        check("dis_bg", bg_th, 8'h55);
        check("dis_alpha", alpha, 8'h77);

        // Abort warm-up after two frames; re-enable restarts the count.
        enable = 1;
        k = 0;
        while (!(m_state == S_WARMUP) && k < 200) begin cyc(); k++; end
        bound("wu_enter_timeout", k, 200);
        f0 = m_fcnt;
        k = 0;
        while (!(m_fcnt == f0 + 2) && k < 500) begin cyc(); k++; end
        bound("wu_frames_timeout", k, 500);
        enable = 0;
        stalls = 0; k = 0;
        while (!(m_state == S_IDLE) && k < 500) begin
            cyc();
            if (stall) stalls++;
            k++;
        end
        bound("wu_abort_timeout", k, 500);
        check("wu_abort_stall", stalls, 0);
        check("wu_abort_state", state, 0);
        enable = 1;
        k = 0;
        while (!(m_state == S_WARMUP) && k < 200) begin cyc(); k++; end
        bound("wu_reenter_timeout", k, 200);
        f0 = m_fcnt;
        k = 0;
        while (!stall && k < 1000) begin cyc(); k++; end
        bound("wu_restart_timeout", k, 1000);
        check("wu_restart_frames", 32'(frame_count) - f0, WF);

        // Reset in the third drain cycle.
        check("rst_drain_c1", stall, 1);
        cyc(); cyc();
        check("rst_drain_c3", stall, 1);
        areset = 1;
        cyc();
        areset = 0;
        check("rst_mid_stall", stall, 0);
        check("rst_mid_state", state, 0);
        check("rst_mid_ce", ce, 0);
        check("rst_mid_fcnt", frame_count, 0);
        check("rst_mid_bg", bg_th, 0);
        check("rst_mid_fd", fd_th, 0);
        check("rst_mid_alpha", alpha, 0);

        // Randomized traffic, control and configuration.
        glitch_en = 1; len_min = 1; len_max = 6;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            cfg_update = ($urandom_range(0, 39) == 0);
            cfg_bg_th  = 8'($urandom);
            cfg_fd_th  = 8'($urandom);
            cfg_alpha  = 8'($urandom);
            areset     = ($urandom_range(0, 1999) == 0);
            cyc();
        end
        cfg_update = 0;
        areset = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
